// File: rtl/stopwatch_counter.sv
// BCD MM:SS stopwatch driven by quarter-second ticks from the divider square wave.
// Supports run/pause and a blinking per-field adjust mode.
module stopwatch_counter (
    input  logic       src_clk,
    input  logic       src_rst,
    input  logic       four_hz_in,
    input  logic       pause_pulse,
    input  logic       adj,
    input  logic       sel,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic [3:0] digit_blank,
    output logic       tick_1hz
);

    logic       prev_q, prev_d;
    logic [1:0] q_q, q_d;
    logic       paused_q, paused_d;
    logic       blink_q, blink_d;
    logic [7:0] min_q, min_d;
    logic [7:0] sec_q, sec_d;
    logic [3:0] blank_q, blank_d;
    logic       tick_q, tick_d;

    logic       qtick;
    logic       count_en;
    logic       adj_en;
    logic [7:0] sec_inc;
    logic [7:0] min_inc;

    // Two-digit BCD increment that wraps 59 -> 00.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        logic [7:0] r;
        if (v[3:0] == 4'd9) begin
            if (v[7:4] == 4'd5) r = 8'h00;
            else                r = {v[7:4] + 4'd1, 4'd0};
        end else begin
            r = {v[7:4], v[3:0] + 4'd1};
        end
        return r;
    endfunction

    always_comb begin
        qtick    = four_hz_in & ~prev_q;
        sec_inc  = bcd_inc(sec_q);
        min_inc  = bcd_inc(min_q);
        count_en = ~adj & ~paused_q & qtick & (q_q == 2'd3);
        adj_en   = adj & qtick & q_q[0];

        prev_d   = four_hz_in;
        q_d      = qtick ? q_q + 2'd1 : q_q;
        paused_d = (~adj & pause_pulse) ? ~paused_q : paused_q;
        blink_d  = adj ? (blink_q ^ qtick) : 1'b0;
        min_d    = min_q;
        sec_d    = sec_q;
        tick_d   = 1'b0;

        // Counting decision uses paused_q, i.e. the state before any toggle.
        if (count_en) begin
            sec_d  = sec_inc;
            tick_d = 1'b1;
            if (sec_q == 8'h59) min_d = min_inc;
        end

        if (adj_en) begin
            if (sel) sec_d = sec_inc;
            else     min_d = min_inc;
        end

        blank_d = 4'b0000;
        if (adj & blink_d) blank_d = sel ? 4'b0011 : 4'b1100;
    end

    always_ff @(posedge src_clk) begin
        if (src_rst) begin
            prev_q   <= 1'b0;
            q_q      <= 2'd0;
            paused_q <= 1'b0;
            blink_q  <= 1'b0;
            min_q    <= 8'h00;
            sec_q    <= 8'h00;
            blank_q  <= 4'b0000;
            tick_q   <= 1'b0;
        end else begin
            prev_q   <= prev_d;
            q_q      <= q_d;
            paused_q <= paused_d;
            blink_q  <= blink_d;
            min_q    <= min_d;
            sec_q    <= sec_d;
            blank_q  <= blank_d;
            tick_q   <= tick_d;
        end
    end

    assign min_tens    = min_q[7:4];
    assign min_ones    = min_q[3:0];
    assign sec_tens    = sec_q[7:4];
    assign sec_ones    = sec_q[3:0];
    assign digit_blank = blank_q;
    assign tick_1hz    = tick_q;

endmodule
